// File: rtl/hamming_dec_pipe.sv
// Two-stage SECDED-style decoder for the multi-mode parity encoder.
// Stage 1 recomputes parity and registers the syndrome. Stage 2 classifies
// the word, corrects it if it can, and drives the result. Valid/ready flow
// control is used on both sides, and saturating error counters are kept.
module hamming_dec_pipe #(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MAX_INFO_WIDTH     = 26,
  parameter logic [(MAX_CODEWORD_WIDTH-MAX_INFO_WIDTH)*MAX_INFO_WIDTH-1:0] H1_MAT =
    156'hE0_0000_3400_000B,
  parameter logic [(MAX_CODEWORD_WIDTH-MAX_INFO_WIDTH)*MAX_INFO_WIDTH-1:0] H2_MAT =
    156'h1FC_0000_78E0_0019_B400_055B,
  parameter logic [(MAX_CODEWORD_WIDTH-MAX_INFO_WIDTH)*MAX_INFO_WIDTH-1:0] H3_MAT =
    156'h3_FFF8_00FF_01FC_3C3C_78EC_CCD9_B6AA_AD5B,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MAX_CODEWORD_WIDTH-1:0] codeword_in,
  input  logic [1:0]                    work_mod,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MAX_INFO_WIDTH-1:0]     data_out,
  output logic                          err_corrected,
  output logic                          err_uncorrectable,
  input  logic                          cnt_clr,
  output logic [CNT_WIDTH-1:0]          corr_cnt,
  output logic [CNT_WIDTH-1:0]          uncorr_cnt
);

  localparam int MAX_PARITY_WIDTH = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH;
  localparam int IW = MAX_INFO_WIDTH;
  localparam int PW = MAX_PARITY_WIDTH;

  typedef enum logic [1:0] {
    MODE_4_4  = 2'b00,
    MODE_11_5 = 2'b01,
    MODE_26_6 = 2'b10,
    MODE_ILL  = 2'b11
  } mode_e;

  function automatic logic [PW*IW-1:0] h_sel(input mode_e m);
    case (m)
      MODE_4_4:  return H1_MAT;
      MODE_11_5: return H2_MAT;
      MODE_26_6: return H3_MAT;
      default:   return '0;
    endcase
  endfunction

  function automatic logic [IW-1:0] info_mask(input mode_e m);
    case (m)
      MODE_4_4:  return IW'(32'h0000_000F);
      MODE_11_5: return IW'(32'h0000_07FF);
      MODE_26_6: return IW'(32'h03FF_FFFF);
      default:   return '0;
    endcase
  endfunction

  function automatic logic [PW-1:0] par_mask(input mode_e m);
    case (m)
      MODE_4_4:  return PW'(8'h0F);
      MODE_11_5: return PW'(8'h1F);
      MODE_26_6: return PW'(8'h3F);
      default:   return '0;
    endcase
  endfunction

  function automatic int par_shift(input mode_e m);
    case (m)
      MODE_4_4:  return 4;
      MODE_11_5: return 5;
      MODE_26_6: return 6;
      default:   return 0;
    endcase
  endfunction

  // One-hot flip vector of the lowest info column equal to the syndrome.
  function automatic logic [IW-1:0] col_match(input mode_e m, input logic [PW-1:0] syn);
    logic [PW*IW-1:0] h;
    logic [PW-1:0]    col;
    logic [IW-1:0]    kmask;
    logic [PW-1:0]    pmask;
    col_match = '0;
    h         = h_sel(m);
    kmask     = info_mask(m);
    pmask     = par_mask(m);
    for (int c = IW - 1; c >= 0; c--) begin
      for (int r = 0; r < PW; r++) col[r] = h[r*IW+c];
      if (kmask[c] && ((col & pmask) == syn)) col_match = IW'(1) << c;
    end
  endfunction

  mode_e             w_mode;
  logic [PW*IW-1:0]  w_h;
  logic [IW-1:0]     w_info;
  logic [PW-1:0]     w_rx_par;
  logic [PW-1:0]     w_calc;
  logic [PW-1:0]     w_syn;
  logic [IW-1:0]     w_flip;
  logic [IW-1:0]     w_data;
  logic              w_corr;
  logic              w_unc;
  logic              w_s1_en;
  logic              w_s2_en;
  logic              w_accept;
  logic              w_deliver;

  logic              r_run;
  logic              r_s1_valid;
  logic [IW-1:0]     r_s1_info;
  mode_e             r_s1_mode;
  logic [PW-1:0]     r_s1_syn;
  logic              r_s2_valid;
  logic [IW-1:0]     r_data_out;
  logic              r_err_corr;
  logic              r_err_unc;
  logic [CNT_WIDTH-1:0] r_corr_cnt;
  logic [CNT_WIDTH-1:0] r_uncorr_cnt;

  // A stage may load when it is empty or its contents move on this cycle.
  assign w_s2_en   = !r_s2_valid || out_ready;
  assign w_s1_en   = !r_s1_valid || w_s2_en;
  assign in_ready  = r_run && w_s1_en;
  assign w_accept  = in_valid && in_ready;
  assign w_deliver = r_s2_valid && out_ready;

  // Split the incoming codeword by mode and form the syndrome.
  // NOTE: every variable written here gets a value before any branch or loop, so no latch is inferred.
  always_comb begin
    w_mode   = mode_e'(work_mod);
    w_h      = h_sel(w_mode);
    w_info   = IW'(codeword_in >> par_shift(w_mode)) & info_mask(w_mode);
    w_rx_par = PW'(codeword_in) & par_mask(w_mode);
    w_calc   = '0;
    for (int r = 0; r < PW; r++) begin
      for (int c = 0; c < IW; c++) begin
        w_calc[r] = w_calc[r] ^ (w_h[r*IW+c] & w_info[c]);
      end
    end
    w_syn = (w_calc ^ w_rx_par) & par_mask(w_mode);
  end

  // Classify the stage-1 word in priority order and build the result.
  always_comb begin
    w_flip = col_match(r_s1_mode, r_s1_syn);
    w_data = r_s1_info;
    w_corr = 1'b0;
    w_unc  = 1'b0;
    if (r_s1_mode == MODE_ILL) begin
      w_data = '0;
      w_unc  = 1'b1;
    end else if (r_s1_syn == '0) begin
      w_data = r_s1_info;
    end else if (w_flip != '0) begin
      w_data = r_s1_info ^ w_flip;
      w_corr = 1'b1;
    end else if ($onehot(r_s1_syn)) begin
      w_corr = 1'b1;
    end else begin
      w_unc = 1'b1;
    end
  end

  // Hold off input acceptance until the first clock after reset release.
  // NOTE: clocked state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_run <= 1'b0;
    else      r_run <= 1'b1;
  end

  // Stage 1: capture info, mode and syndrome on each accepted word.
  // NOTE: payload registers are reset too, because data_out must read zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_info  <= '0;
      r_s1_mode  <= MODE_4_4;
      r_s1_syn   <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_info <= w_info;
        r_s1_mode <= w_mode;
        r_s1_syn  <= w_syn;
      end
    end
  end

  // Stage 2: register the corrected word and flags; they hold while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_valid <= 1'b0;
      r_data_out <= '0;
      r_err_corr <= 1'b0;
      r_err_unc  <= 1'b0;
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_data_out <= w_data;
        r_err_corr <= w_corr;
        r_err_unc  <= w_unc;
      end
    end
  end

  // Saturating statistics; a clear wins over a coincident increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (cnt_clr) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (w_deliver) begin
      if (r_err_corr && (r_corr_cnt != '1))  r_corr_cnt   <= r_corr_cnt + CNT_WIDTH'(1);
      if (r_err_unc && (r_uncorr_cnt != '1)) r_uncorr_cnt <= r_uncorr_cnt + CNT_WIDTH'(1);
    end
  end

  assign out_valid         = r_s2_valid;
  assign data_out          = r_data_out;
  assign err_corrected     = r_err_corr;
  assign err_uncorrectable = r_err_unc;
  assign corr_cnt          = r_corr_cnt;
  assign uncorr_cnt        = r_uncorr_cnt;

endmodule
